frame_buffer_writer: RTL and testbench

Parametrised successor to the single-frame SRAM write port. Takes scaled pixels from the scaler in the 25 MHz pixel domain and writes them into a one- or two-bank BRAM frame buffer. A frame-sync pulse arriving from the camera PCLK domain marks frame boundaries. Adds ping-pong bank switching, whole-frame validation (short and long frames), and aligned address/data/enable. The display reader always gets a complete, stable bank.

---
 rtl/fb_pkg.sv | 22 ++
 rtl/frame_buffer_writer_if.sv | 26 ++
 rtl/sync_edge_det.sv | 35 +++
 rtl/frame_buffer_writer.sv | 141 ++++++++++++++
 tb/tb_frame_buffer_writer.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// Shared types and helpers for the frame buffer writer and its companions.
package fb_pkg;

  typedef enum logic [1:0] {
    StWaitSync,
    StActive,
    StFull
  } fb_state_e;

  localparam int unsigned PixWDefault = 12;
  localparam int unsigned HResDefault = 320;
  localparam int unsigned VResDefault = 240;

  function automatic int unsigned frame_pix(input int unsigned h_res, input int unsigned v_res);
    return h_res * v_res;
  endfunction

  function automatic int unsigned bank_base(input logic bank, input int unsigned frame_pixels);
    return bank ? frame_pixels : 0;
  endfunction

endpackage

// File: rtl/frame_buffer_writer_if.sv
// Pixel-in / BRAM-write-out bundle between the scaler, the writer and the display side.
interface frame_buffer_writer_if #(
  parameter int unsigned PIX_W  = 12,
  parameter int unsigned ADDR_W = 18
);
  logic              scaled_valid;
  logic [PIX_W-1:0]  scaled_data;
  logic              clr_err;
  logic [ADDR_W-1:0] bram_addr;
  logic [PIX_W-1:0]  bram_data;
  logic              bram_we;
  logic              disp_bank;
  logic              frame_done;
  logic              err_short;
  logic              err_long;

  modport master (
    output scaled_valid, scaled_data, clr_err,
    input  bram_addr, bram_data, bram_we, disp_bank, frame_done, err_short, err_long
  );

  modport slave (
    input  scaled_valid, scaled_data, clr_err,
    output bram_addr, bram_data, bram_we, disp_bank, frame_done, err_short, err_long
  );
endinterface

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous level followed by a registered rising-edge pulse.
module sync_edge_det #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic pulse_o
);

  logic [Stages-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;
  logic              pulse_q, pulse_d;

  always_comb begin
    sync_d  = {sync_q[Stages-2:0], async_i};
    prev_d  = sync_q[Stages-1];
    pulse_d = sync_q[Stages-1] & ~prev_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/frame_buffer_writer.sv
// Writes scaled pixels into a one- or two-bank frame buffer and publishes only complete frames.
module frame_buffer_writer
  import fb_pkg::*;
#(
  parameter int unsigned PIX_W       = PixWDefault,
  parameter int unsigned H_RES       = HResDefault,
  parameter int unsigned V_RES       = VResDefault,
  parameter int unsigned NUM_BANKS   = 2,
  parameter int unsigned ADDR_W      = 18,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  input logic                  frame_sync,
  frame_buffer_writer_if.slave bus
);

  localparam int unsigned FRAME_PIX = frame_pix(H_RES, V_RES);
  localparam int unsigned CntW      = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;

  if (NUM_BANKS != 1 && NUM_BANKS != 2) begin : g_bad_banks
    $error("frame_buffer_writer: NUM_BANKS must be 1 or 2");
  end
  if ((64'd1 << ADDR_W) < 64'(NUM_BANKS) * 64'(FRAME_PIX)) begin : g_bad_addr_w
    $error("frame_buffer_writer: ADDR_W too small for NUM_BANKS*FRAME_PIX");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("frame_buffer_writer: SYNC_STAGES must be at least 2");
  end

  logic sof;

  sync_edge_det #(
    .Stages(SYNC_STAGES)
  ) u_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .async_i(frame_sync),
    .pulse_o(sof)
  );

  fb_state_e         state_q, state_d;
  logic [CntW-1:0]   pix_cnt_q, pix_cnt_d;
  logic              wr_bank_q, wr_bank_d;
  logic              disp_bank_q, disp_bank_d;
  logic              frame_done_q, frame_done_d;
  logic              err_short_q, err_short_d;
  logic              err_long_q, err_long_d;
  logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
  logic [PIX_W-1:0]  bram_data_q, bram_data_d;
  logic              bram_we_q, bram_we_d;

  always_comb begin
    state_d      = state_q;
    pix_cnt_d    = pix_cnt_q;
    wr_bank_d    = wr_bank_q;
    disp_bank_d  = disp_bank_q;
    frame_done_d = 1'b0;
    bram_we_d    = 1'b0;
    bram_addr_d  = bram_addr_q;
    bram_data_d  = bram_data_q;
    // Clear first so that a same-cycle set below takes priority.
    err_short_d  = err_short_q & ~bus.clr_err;
    err_long_d   = err_long_q & ~bus.clr_err;

    case (state_q)
      StWaitSync: begin
        if (sof) begin
          state_d   = StActive;
          pix_cnt_d = '0;
        end
      end
      StActive: begin
        if (sof) begin
          // Frame cut short: restart in the same bank without publishing.
          err_short_d = 1'b1;
          pix_cnt_d   = '0;
        end else if (bus.scaled_valid) begin
          bram_we_d   = 1'b1;
          bram_addr_d = ADDR_W'(bank_base(wr_bank_q, FRAME_PIX)) + ADDR_W'(pix_cnt_q);
          bram_data_d = bus.scaled_data;
          if (pix_cnt_q == CntW'(FRAME_PIX - 1)) begin
            state_d = StFull;
          end else begin
            pix_cnt_d = pix_cnt_q + CntW'(1);
          end
        end
      end
      StFull: begin
        if (sof) begin
          disp_bank_d  = wr_bank_q;
          frame_done_d = 1'b1;
          wr_bank_d    = (NUM_BANKS == 2) ? ~wr_bank_q : wr_bank_q;
          state_d      = StActive;
          pix_cnt_d    = '0;
        end else if (bus.scaled_valid) begin
          err_long_d = 1'b1;
        end
      end
      default: begin
        state_d   = StWaitSync;
        pix_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StWaitSync;
      pix_cnt_q    <= '0;
      wr_bank_q    <= 1'b0;
      disp_bank_q  <= 1'b0;
      frame_done_q <= 1'b0;
      err_short_q  <= 1'b0;
      err_long_q   <= 1'b0;
      bram_addr_q  <= '0;
      bram_data_q  <= '0;
      bram_we_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_cnt_q    <= pix_cnt_d;
      wr_bank_q    <= wr_bank_d;
      disp_bank_q  <= disp_bank_d;
      frame_done_q <= frame_done_d;
      err_short_q  <= err_short_d;
      err_long_q   <= err_long_d;
      bram_addr_q  <= bram_addr_d;
      bram_data_q  <= bram_data_d;
      bram_we_q    <= bram_we_d;
    end
  end

  assign bus.bram_addr  = bram_addr_q;
  assign bus.bram_data  = bram_data_q;
  assign bus.bram_we    = bram_we_q;
  assign bus.disp_bank  = disp_bank_q;
  assign bus.frame_done = frame_done_q;
  assign bus.err_short  = err_short_q;
  assign bus.err_long   = err_long_q;

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Directed bench for frame_buffer_writer: a 4x2 two-bank instance and a 4x2 single-bank instance.
module tb_frame_buffer_writer;

  localparam int unsigned PW = 12;
  localparam int unsigned AW = 4;

  logic clk;
  logic rst_n;
  logic fs0;
  logic fs1;
  int   checks   = 0;
  int   failures = 0;

  frame_buffer_writer_if #(.PIX_W(PW), .ADDR_W(AW)) bus0 ();
  frame_buffer_writer_if #(.PIX_W(PW), .ADDR_W(AW)) bus1 ();

  frame_buffer_writer #(
    .PIX_W(PW), .H_RES(4), .V_RES(2), .NUM_BANKS(2), .ADDR_W(AW), .SYNC_STAGES(2)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .frame_sync(fs0), .bus(bus0.slave)
  );

  frame_buffer_writer #(
    .PIX_W(PW), .H_RES(4), .V_RES(2), .NUM_BANKS(1), .ADDR_W(AW), .SYNC_STAGES(2)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .frame_sync(fs1), .bus(bus1.slave)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  // Write / commit monitor, sampled on the falling edge.
  logic [AW-1:0] wa0[$];
  logic [PW-1:0] wd0[$];
  logic [AW-1:0] wa1[$];
  int done0 = 0;
  int done1 = 0;

  always @(negedge clk) begin
    if (bus0.bram_we === 1'b1) begin
      wa0.push_back(bus0.bram_addr);
      wd0.push_back(bus0.bram_data);
    end
    if (bus1.bram_we === 1'b1) wa1.push_back(bus1.bram_addr);
    if (bus0.frame_done === 1'b1) done0++;
    if (bus1.frame_done === 1'b1) done1++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Raise frame_sync, wait until sof is visible, optionally present a pixel in the sof cycle.
  task automatic sof_pulse(input int which, input bit with_pix, input logic [PW-1:0] d);
    if (which == 0) fs0 = 1'b1; else fs1 = 1'b1;
    step(3);
    if (which == 0) fs0 = 1'b0; else fs1 = 1'b0;
    if (with_pix) begin
      bus0.scaled_valid = 1'b1;
      bus0.scaled_data  = d;
    end
    step(1);
    bus0.scaled_valid = 1'b0;
  endtask

  task automatic send_pix(input int which, input int n, input logic [PW-1:0] base);
    for (int i = 0; i < n; i++) begin
      if (which == 0) begin
        bus0.scaled_valid = 1'b1;
        bus0.scaled_data  = base + PW'(i);
      end else begin
        bus1.scaled_valid = 1'b1;
        bus1.scaled_data  = base + PW'(i);
      end
      step(1);
    end
    bus0.scaled_valid = 1'b0;
    bus1.scaled_valid = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    fs0 = 1'b0;
    fs1 = 1'b0;
    bus0.scaled_valid = 1'b0; bus0.scaled_data = '0; bus0.clr_err = 1'b0;
    bus1.scaled_valid = 1'b0; bus1.scaled_data = '0; bus1.clr_err = 1'b0;
    step(2);
    checks += 7;
    if (bus0.bram_we !== 1'b0) begin failures++; $display("FAIL reset_we got %b exp 0", bus0.bram_we); end
    if (bus0.bram_addr !== '0) begin failures++; $display("FAIL reset_addr got %0h exp 0", bus0.bram_addr); end
    if (bus0.bram_data !== '0) begin failures++; $display("FAIL reset_data got %0h exp 0", bus0.bram_data); end
    if (bus0.disp_bank !== 1'b0) begin failures++; $display("FAIL reset_disp got %b exp 0", bus0.disp_bank); end
    if (bus0.frame_done !== 1'b0) begin failures++; $display("FAIL reset_done got %b exp 0", bus0.frame_done); end
    if (bus0.err_short !== 1'b0) begin failures++; $display("FAIL reset_eshort got %b exp 0", bus0.err_short); end
    if (bus0.err_long !== 1'b0) begin failures++; $display("FAIL reset_elong got %b exp 0", bus0.err_long); end
    rst_n = 1'b1;
    step(2);
    // Pixels before any sof must be discarded.
    send_pix(0, 3, 12'h0f0);
    checks++;
    if (wa0.size() != 0) begin failures++; $display("FAIL waitsync_drop got %0d writes exp 0", wa0.size()); end
  endtask

  task automatic test_full_frame();
    wa0.delete(); wd0.delete();
    sof_pulse(0, 1'b0, '0);
    send_pix(0, 8, 12'h100);
    checks++;
    if (wa0.size() != 8) begin failures++; $display("FAIL ff_count got %0d exp 8", wa0.size()); end
    for (int i = 0; i < 8 && i < wa0.size(); i++) begin
      checks += 2;
      if (wa0[i] !== AW'(i)) begin failures++; $display("FAIL ff_addr[%0d] got %0h exp %0h", i, wa0[i], i); end
      if (wd0[i] !== 12'h100 + PW'(i)) begin failures++; $display("FAIL ff_data[%0d] got %0h exp %0h", i, wd0[i], 12'h100 + i); end
    end
    checks++;
    if (done0 != 0) begin failures++; $display("FAIL ff_early_done got %0d exp 0", done0); end
    sof_pulse(0, 1'b0, '0);
    checks += 2;
    if (bus0.frame_done !== 1'b1) begin failures++; $display("FAIL ff_done1 got %b exp 1", bus0.frame_done); end
    if (bus0.disp_bank !== 1'b0) begin failures++; $display("FAIL ff_disp0 got %b exp 0", bus0.disp_bank); end
    step(1);
    checks++;
    if (bus0.frame_done !== 1'b0) begin failures++; $display("FAIL ff_done_pulse got %b exp 0", bus0.frame_done); end
    wa0.delete(); wd0.delete();
    send_pix(0, 8, 12'h200);
    checks++;
    if (wa0.size() != 8) begin failures++; $display("FAIL ff2_count got %0d exp 8", wa0.size()); end
    for (int i = 0; i < 8 && i < wa0.size(); i++) begin
      checks += 2;
      if (wa0[i] !== AW'(8 + i)) begin failures++; $display("FAIL ff2_addr[%0d] got %0h exp %0h", i, wa0[i], 8 + i); end
      if (wd0[i] !== 12'h200 + PW'(i)) begin failures++; $display("FAIL ff2_data[%0d] got %0h exp %0h", i, wd0[i], 12'h200 + i); end
    end
    sof_pulse(0, 1'b0, '0);
    checks += 2;
    if (bus0.frame_done !== 1'b1) begin failures++; $display("FAIL ff_done2 got %b exp 1", bus0.frame_done); end
    if (bus0.disp_bank !== 1'b1) begin failures++; $display("FAIL ff_disp1 got %b exp 1", bus0.disp_bank); end
  endtask

  task automatic test_short_frame();
    wa0.delete(); wd0.delete();
    send_pix(0, 5, 12'h300);
    sof_pulse(0, 1'b0, '0);
    checks += 2;
    if (bus0.err_short !== 1'b1) begin failures++; $display("FAIL sf_err got %b exp 1", bus0.err_short); end
    if (bus0.disp_bank !== 1'b1) begin failures++; $display("FAIL sf_disp got %b exp 1", bus0.disp_bank); end
    send_pix(0, 2, 12'h310);
    checks += 4;
    if (done0 != 2) begin failures++; $display("FAIL sf_done got %0d exp 2", done0); end
    if (wa0.size() != 7) begin failures++; $display("FAIL sf_count got %0d exp 7", wa0.size()); end
    else begin
      if (wa0[5] !== AW'(0)) begin failures++; $display("FAIL sf_restart0 got %0h exp 0", wa0[5]); end
      if (wa0[6] !== AW'(1)) begin failures++; $display("FAIL sf_restart1 got %0h exp 1", wa0[6]); end
    end
  endtask

  task automatic test_long_frame();
    sof_pulse(0, 1'b0, '0);
    bus0.clr_err = 1'b1;
    step(1);
    bus0.clr_err = 1'b0;
    checks++;
    if (bus0.err_short !== 1'b0) begin failures++; $display("FAIL lf_clr_short got %b exp 0", bus0.err_short); end
    wa0.delete(); wd0.delete();
    send_pix(0, 10, 12'h400);
    checks += 2;
    if (wa0.size() != 8) begin failures++; $display("FAIL lf_count got %0d exp 8", wa0.size()); end
    if (bus0.err_long !== 1'b1) begin failures++; $display("FAIL lf_err got %b exp 1", bus0.err_long); end
    for (int i = 0; i < 8 && i < wa0.size(); i++) begin
      checks++;
      if (wa0[i] !== AW'(i) || wd0[i] !== 12'h400 + PW'(i)) begin
        failures++;
        $display("FAIL lf_write[%0d] got %0h/%0h exp %0h/%0h", i, wa0[i], wd0[i], i, 12'h400 + i);
      end
    end
    bus0.clr_err = 1'b1;
    step(1);
    bus0.clr_err = 1'b0;
    checks++;
    if (bus0.err_long !== 1'b0) begin failures++; $display("FAIL lf_clr_long got %b exp 0", bus0.err_long); end
  endtask

  task automatic test_simultaneous();
    wa0.delete(); wd0.delete();
    sof_pulse(0, 1'b1, 12'habc);
    checks += 2;
    if (bus0.frame_done !== 1'b1) begin failures++; $display("FAIL sim_done got %b exp 1", bus0.frame_done); end
    if (bus0.disp_bank !== 1'b0) begin failures++; $display("FAIL sim_disp got %b exp 0", bus0.disp_bank); end
    send_pix(0, 1, 12'h055);
    checks += 2;
    if (bus0.err_long !== 1'b0) begin failures++; $display("FAIL sim_noerr got %b exp 0", bus0.err_long); end
    if (wa0.size() != 1) begin failures++; $display("FAIL sim_count got %0d exp 1", wa0.size()); end
    else begin
      checks++;
      if (wa0[0] !== AW'(8) || wd0[0] !== 12'h055) begin
        failures++;
        $display("FAIL sim_first got %0h/%0h exp 8/055", wa0[0], wd0[0]);
      end
    end
    // Clear held across an err_short set: set must win.
    bus0.clr_err = 1'b1;
    sof_pulse(0, 1'b0, '0);
    bus0.clr_err = 1'b0;
    checks++;
    if (bus0.err_short !== 1'b1) begin failures++; $display("FAIL sim_setwins got %b exp 1", bus0.err_short); end
    bus0.clr_err = 1'b1;
    step(1);
    bus0.clr_err = 1'b0;
  endtask

  task automatic test_async_reset();
    wa0.delete(); wd0.delete();
    for (int i = 0; i < 3; i++) begin
      bus0.scaled_valid = 1'b1;
      bus0.scaled_data  = 12'h600 + PW'(i);
      step(1);
    end
    @(negedge clk);
    #1;
    checks += 2;
    if (bus0.bram_we !== 1'b1) begin failures++; $display("FAIL ar_we_before got %b exp 1", bus0.bram_we); end
    if (wa0.size() != 3 || wa0[0] !== AW'(8) || wa0[2] !== AW'(10)) begin
      failures++;
      $display("FAIL ar_writes got %0d writes exp 3 at 8..10", wa0.size());
    end
    #5 rst_n = 1'b0;
    #1;
    checks += 2;
    if (bus0.bram_we !== 1'b0) begin failures++; $display("FAIL ar_we_async got %b exp 0", bus0.bram_we); end
    if (bus0.bram_addr !== '0) begin failures++; $display("FAIL ar_addr_async got %0h exp 0", bus0.bram_addr); end
    wa0.delete(); wd0.delete();
    step(2);
    rst_n = 1'b1;
    step(4);
    bus0.scaled_valid = 1'b0;
    step(1);
    checks++;
    if (wa0.size() != 0) begin failures++; $display("FAIL ar_nowrite got %0d exp 0", wa0.size()); end
    sof_pulse(0, 1'b0, '0);
    send_pix(0, 2, 12'h700);
    checks++;
    if (wa0.size() != 2 || wa0[0] !== AW'(0) || wa0[1] !== AW'(1)) begin
      failures++;
      $display("FAIL ar_restart got %0d writes exp 2 at 0..1", wa0.size());
    end
  endtask

  task automatic test_single_bank();
    sof_pulse(1, 1'b0, '0);
    for (int f = 0; f < 3; f++) begin
      wa1.delete();
      send_pix(1, 8, 12'h800 + PW'(f * 16));
      checks++;
      if (wa1.size() != 8) begin failures++; $display("FAIL sb_count[%0d] got %0d exp 8", f, wa1.size()); end
      for (int i = 0; i < 8 && i < wa1.size(); i++) begin
        checks++;
        if (wa1[i] !== AW'(i)) begin failures++; $display("FAIL sb_addr[%0d][%0d] got %0h exp %0h", f, i, wa1[i], i); end
      end
      sof_pulse(1, 1'b0, '0);
      checks += 2;
      if (bus1.frame_done !== 1'b1) begin failures++; $display("FAIL sb_done[%0d] got %b exp 1", f, bus1.frame_done); end
      if (bus1.disp_bank !== 1'b0) begin failures++; $display("FAIL sb_disp[%0d] got %b exp 0", f, bus1.disp_bank); end
    end
    step(1);
    checks++;
    if (done1 != 3) begin failures++; $display("FAIL sb_done_total got %0d exp 3", done1); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_short_frame();
    test_long_frame();
    test_simultaneous();
    test_async_reset();
    test_single_bank();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
